bank_req_fifo: RTL and testbench
================================

BANK_REQ_FIFO -- requirements
Module: bank_req_fifo

Interface
REQ-001 The block SHALL have parameter PLD_WIDTH, default 32, giving request payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving entry count; it must be a power of two and at least 2.
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-1, giving the occupancy at which afull asserts.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_vld, input, 1 bit: an xbar output port offers a request.
REQ-007 The block SHALL have port in_pld, input, PLD_WIDTH bits: the offered request payload.
REQ-008 The block SHALL have port in_rdy, output, 1 bit: the FIFO accepts a request this cycle; it drives the xbar out_rdy.
REQ-009 The block SHALL have port flush, input, 1 bit: discard all stored entries.
REQ-010 The block SHALL have port out_vld, output, 1 bit: the head entry is presented to the bank pipeline.
REQ-011 The block SHALL have port out_pld, output, PLD_WIDTH bits: the head entry payload.
REQ-012 The block SHALL have port out_rdy, input, 1 bit: the bank pipeline consumes the head entry.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-014 The block SHALL have port afull, output, 1 bit: asserted when count >= AFULL_TH.

Function
REQ-015 A push SHALL occur when in_vld && in_rdy; a pop SHALL occur when out_vld && out_rdy.
REQ-016 in_rdy SHALL equal !full, a function of registered state only, never of in_vld or out_rdy, so it breaks the xbar rdy->vld combinational path.
REQ-017 out_vld SHALL equal !empty, a function of registered state only; out_pld SHALL be the storage entry at the read pointer.
REQ-018 A pushed entry SHALL become visible at out_vld no earlier than the next cycle; there is no same-cycle bypass.
REQ-019 Entries SHALL pop in push order.
REQ-020 Read and write pointers SHALL be $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
REQ-021 full SHALL be true when the pointers differ only in the MSB; empty SHALL be true when the pointers are equal.
REQ-022 count SHALL update as count+1 on push only, count-1 on pop only, and stay unchanged on push and pop together.
REQ-023 When full, a simultaneous pop SHALL NOT enable a push in the same cycle, because in_rdy is already 0.
REQ-024 When empty, a push SHALL be accepted, and out_vld SHALL assert the following cycle.
REQ-025 flush SHALL clear both pointers and count on the next edge, overriding any push or pop in the same cycle; the flush-cycle push SHALL be dropped even though in_rdy was 1 (the upstream agent owns flush coordination).
REQ-026 out_pld SHALL be don't-care while out_vld is 0, and storage SHALL NOT be reset.
REQ-027 afull SHALL be registered, computed from next-state count, so it is timing-aligned with count.

Reset
REQ-028 While rst is high, on each clk edge: pointers = 0, count = 0, afull = 0; therefore in_rdy = 1 and out_vld = 0 from the first cycle after reset.
REQ-029 Assertion of rst mid-operation SHALL discard all entries exactly as flush does; it takes priority over flush, push and pop.

Structure
REQ-030 The shared package vc_xbar_pkg SHALL hold the output-port count constant (4) and the default FIFO DEPTH; PLD_WIDTH remains a module parameter.
REQ-031 The block SHALL use no sub-module; storage SHALL be a DEPTH x PLD_WIDTH flop array written at the write-pointer index.
REQ-032 One instance SHALL sit on each of the four xbar output ports.

Verification
REQ-033 Bench SHALL cover: reset, then push 0xA1, 0xA2, 0xA3 with out_rdy=0 -> count=3, afull=1 (DEPTH=4), out_pld=0xA1.
REQ-034 Bench SHALL cover: fill 4 entries with out_rdy=0 -> in_rdy=0; with in_vld=1 and out_rdy=1 that cycle, only a pop occurs -> count=3, and the push lands on the next cycle.
REQ-035 Bench SHALL cover: from empty, push 0x55 in cycle t -> out_vld=0 in t and out_vld=1 with out_pld=0x55 in t+1.
REQ-036 Bench SHALL cover: sustained push and pop at one per cycle over 20 values with pointer wrap -> output order identical to input order, count stable at 1.
REQ-037 Bench SHALL cover: 3 entries stored, flush=1 with in_vld=1 -> next cycle count=0, out_vld=0, pushed payload absent.
REQ-038 Bench SHALL cover: rst asserted for one cycle with 2 entries stored -> count=0, in_rdy=1, out_vld=0 afterwards.

Source files
------------

// File: rtl/vc_xbar_pkg.sv
// Constants shared by the crossbar and the per-output-port request FIFOs.
package vc_xbar_pkg;

  localparam int NUM_OUT_PORTS      = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/bank_req_fifo.sv
// Per-bank request FIFO behind one xbar output port: registered ready/valid on
// both sides, wrap-bit pointers, flush and registered almost-full flag.
module bank_req_fifo
  import vc_xbar_pkg::*;
#(
  parameter int PLD_WIDTH = 32,
  parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
  parameter int AFULL_TH  = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic [PLD_WIDTH-1:0]       in_pld,
  output logic                       in_rdy,
  input  logic                       flush,
  output logic                       out_vld,
  output logic [PLD_WIDTH-1:0]       out_pld,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_afull;
  logic [PLD_WIDTH-1:0] r_mem [DEPTH];

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [CW-1:0]        w_count_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_full  = ((r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}});
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = in_vld && !w_full;
  assign w_pop   = out_rdy && !w_empty;

  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CW'(1);
        2'b01:   w_count_next = r_count - CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_afull <= 1'b0;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_next;
      r_afull <= (w_count_next >= CW'(AFULL_TH));
    end
  end

  // Storage is deliberately left unreset; its contents only matter under out_vld.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_pld;
  end

  assign in_rdy  = !w_full;
  assign out_vld = !w_empty;
  assign out_pld = r_mem[r_rptr[AW-1:0]];
  assign count   = r_count;
  assign afull   = r_afull;

endmodule

// File: tb/tb_bank_req_fifo.sv
// Self-checking bench for bank_req_fifo: scenario tasks plus a scoreboard
// that checks every popped payload against push order.
module tb_bank_req_fifo;
  import vc_xbar_pkg::*;

  localparam int PW    = 32;
  localparam int DEPTH = FIFO_DEPTH_DEFAULT;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic [PW-1:0] in_pld;
  logic          in_rdy;
  logic          flush;
  logic          out_vld;
  logic [PW-1:0] out_pld;
  logic          out_rdy;
  logic [CW-1:0] count;
  logic          afull;

  int            n_tests = 0;
  int            n_fail  = 0;
  bit            mon_en  = 1'b0;
  logic [PW-1:0] sb_q [$];

  bank_req_fifo #(.PLD_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_pld(in_pld), .in_rdy(in_rdy),
    .flush(flush), .out_vld(out_vld), .out_pld(out_pld), .out_rdy(out_rdy),
    .count(count), .afull(afull)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs change at posedge+1, so negedge sees the handshakes of the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst || flush) begin
        sb_q.delete();
      end else begin
        if (out_vld === 1'b1 && out_rdy === 1'b1) begin
          n_tests++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_pop_empty: popped %h with nothing expected", out_pld);
          end else begin
            if (out_pld !== sb_q[0]) begin
              n_fail++;
              $display("FAIL sb_order: got %h expected %h", out_pld, sb_q[0]);
            end else begin
              $display("[TB] pop %h ok", out_pld);
            end
            void'(sb_q.pop_front());
          end
        end
        if (in_vld === 1'b1 && in_rdy === 1'b1) sb_q.push_back(in_pld);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    flush   = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic drain(input string name);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 3 * DEPTH && out_vld === 1'b1; i++) tick();
    n_tests++;
    if (out_vld !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL %s_drain: out_vld=%b count=%0d, need 0/0", name, out_vld, count);
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    in_vld = 1'b0; in_pld = '0; flush = 1'b0; out_rdy = 1'b0; rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (count !== '0 || in_rdy !== 1'b1 || out_vld !== 1'b0 || afull !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: count=%0d in_rdy=%b out_vld=%b afull=%b, need 0/1/0/0",
               count, in_rdy, out_vld, afull);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_fill_afull();
    logic [PW-1:0] vals [3] = '{32'hA1, 32'hA2, 32'hA3};
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_pld = vals[i];
      tick();
    end
    in_vld = 1'b0;
    n_tests++;
    if (count !== CW'(3) || afull !== 1'b1 || out_pld !== 32'hA1 || out_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_afull: count=%0d afull=%b out_pld=%h out_vld=%b, need 3/1/a1/1",
               count, afull, out_pld, out_vld);
    end
    $display("[TB] fill_afull count=%0d afull=%b", count, afull);
    drain("fill_afull");
  endtask

  task automatic test_full_pop();
    out_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_vld = 1'b1; in_pld = 32'hB0 + PW'(i);
      tick();
    end
    in_pld = 32'hB5; in_vld = 1'b1; out_rdy = 1'b1;
    n_tests++;
    if (in_rdy !== 1'b0 || count !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL full_rdy: in_rdy=%b count=%0d, need 0/%0d", in_rdy, count, DEPTH);
    end
    tick();
    n_tests++;
    if (count !== CW'(DEPTH - 1) || in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_only: count=%0d in_rdy=%b, need %0d/1", count, in_rdy, DEPTH - 1);
    end
    out_rdy = 1'b0;
    tick();
    in_vld = 1'b0;
    n_tests++;
    if (count !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL full_push_next: count=%0d, need %0d", count, DEPTH);
    end
    $display("[TB] full_pop count=%0d", count);
    drain("full_pop");
  endtask

  task automatic test_empty_push();
    in_vld = 1'b1; in_pld = 32'h55; out_rdy = 1'b0;
    n_tests++;
    if (out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass: out_vld=%b in push cycle, need 0", out_vld);
    end
    tick();
    in_vld = 1'b0;
    n_tests++;
    if (out_vld !== 1'b1 || out_pld !== 32'h55) begin
      n_fail++;
      $display("FAIL empty_push: out_vld=%b out_pld=%h, need 1/55", out_vld, out_pld);
    end
    $display("[TB] empty_push out_pld=%h", out_pld);
    drain("empty_push");
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] v [20];
    for (int i = 0; i < 20; i++) v[i] = $urandom;
    in_vld = 1'b1; in_pld = v[0]; out_rdy = 1'b0;
    tick();
    for (int i = 1; i < 20; i++) begin
      in_pld = v[i]; out_rdy = 1'b1;
      tick();
      n_tests++;
      if (count !== CW'(1) || out_pld !== v[i]) begin
        n_fail++;
        $display("FAIL stream_%0d: count=%0d out_pld=%h, need 1/%h", i, count, out_pld, v[i]);
      end
    end
    in_vld = 1'b0;
    $display("[TB] back_to_back 20 values streamed");
    drain("stream");
  endtask

  task automatic test_flush();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_pld = 32'hC0 + PW'(i);
      tick();
    end
    in_pld = 32'hDEAD; flush = 1'b1;
    tick();
    flush = 1'b0; in_vld = 1'b0;
    n_tests++;
    if (count !== '0 || out_vld !== 1'b0 || afull !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: count=%0d out_vld=%b afull=%b, need 0/0/0", count, out_vld, afull);
    end
    in_vld = 1'b1; in_pld = 32'h77;
    tick();
    in_vld = 1'b0;
    n_tests++;
    if (count !== CW'(1) || out_pld !== 32'h77) begin
      n_fail++;
      $display("FAIL flush_dropped: count=%0d out_pld=%h, need 1/77", count, out_pld);
    end
    $display("[TB] flush checked");
    drain("flush");
  endtask

  task automatic test_rst_mid();
    out_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_vld = 1'b1; in_pld = 32'hE0 + PW'(i);
      tick();
    end
    in_vld = 1'b1; in_pld = 32'hEE; rst = 1'b1;
    tick();
    rst = 1'b0; in_vld = 1'b0;
    n_tests++;
    if (count !== '0 || in_rdy !== 1'b1 || out_vld !== 1'b0 || afull !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: count=%0d in_rdy=%b out_vld=%b afull=%b, need 0/1/0/0",
               count, in_rdy, out_vld, afull);
    end
    tick();
    n_tests++;
    if (out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_hold: out_vld=%b, need 0", out_vld);
    end
    $display("[TB] rst_mid checked");
  endtask

  initial begin
    idle();
    in_pld = '0;
    test_reset();
    test_fill_afull();
    test_full_pop();
    test_empty_push();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries never popped", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
